// File: rtl/dma_axi_pkg.sv
// Shared AXI constants and write-master state encoding for the 2D DMA masters.
package dma_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_BITS  = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } wr_state_e;

endpackage

// File: rtl/axi_burst_planner.sv
// Sizes the next burst: limited by max burst, rest of the line and the 4 KB page.
module axi_burst_planner
  import dma_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_BURST_BEATS = 16
) (
  input  logic [PAGE_BITS-1:0]    addr_lo,
  input  logic [31:0]             line_done,
  input  logic [31:0]             width,
  output logic [31:0]             burst_bytes_c,
  output logic [7:0]              awlen_c,
  output logic [DATA_WIDTH/8-1:0] last_strb_c,
  output logic                    line_end_c
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned MAX_BYTES  = MAX_BURST_BEATS * BEAT_BYTES;

  logic [31:0]           remain_c;
  logic [31:0]           page_left_c;
  logic [31:0]           beats_c;
  logic [BEAT_SHIFT-1:0] tail_c;

  // Burst length is the tightest of the three limits; tail bytes set the final strobe.
  always_comb begin
    remain_c      = width - line_done;
    page_left_c   = 32'(PAGE_BYTES) - 32'(addr_lo);
    burst_bytes_c = 32'(MAX_BYTES);
    if (remain_c < burst_bytes_c) burst_bytes_c = remain_c;
    if (page_left_c < burst_bytes_c) burst_bytes_c = page_left_c;
    beats_c    = (burst_bytes_c + 32'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
    awlen_c    = 8'(beats_c - 32'd1);
    line_end_c = (burst_bytes_c == remain_c);
    tail_c     = width[BEAT_SHIFT-1:0];
    for (int i = 0; i < int'(BEAT_BYTES); i++) begin
      last_strb_c[i] = (tail_c == '0) || (BEAT_SHIFT'(i) < tail_c);
    end
  end

endmodule

// File: rtl/axi_2d_write_master_p.sv
// AXI4 write master draining a FWFT FIFO into a strided 2D destination region.
module axi_2d_write_master_p
  import dma_axi_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_MAX_BURST_BEATS  = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_dst_addr,
  input  logic [31:0]                       i_img_width,
  input  logic [31:0]                       i_img_height,
  input  logic [31:0]                       i_img_stride,
  output logic                              o_busy,
  output logic                              o_write_done,
  output logic                              o_write_error,
  input  logic                              i_fifo_empty,
  output logic                              o_fifo_rd_en,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_w_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready
);

  localparam int unsigned AW         = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  wr_state_e             state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d, line_start_q, line_start_d;
  logic [31:0]           line_done_q, line_done_d, line_cnt_q, line_cnt_d;
  logic [31:0]           width_q, width_d, height_q, height_d, stride_q, stride_d;
  logic [31:0]           burst_bytes_q, burst_bytes_d;
  logic [7:0]            awlen_q, awlen_d, beat_cnt_q, beat_cnt_d;
  logic [BEAT_BYTES-1:0] last_strb_q, last_strb_d;
  logic                  line_end_q, line_end_d;
  logic                  awvalid_q, awvalid_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d;

  logic [31:0]           plan_bytes_c;
  logic [7:0]            plan_len_c;
  logic [BEAT_BYTES-1:0] plan_strb_c;
  logic                  plan_end_c;
  logic                  last_beat_c;

  axi_burst_planner #(
    .DATA_WIDTH      (C_M_AXI_DATA_WIDTH),
    .MAX_BURST_BEATS (C_MAX_BURST_BEATS)
  ) u_planner (
    .addr_lo       (addr_d[PAGE_BITS-1:0]),
    .line_done     (line_done_d),
    .width         (width_d),
    .burst_bytes_c (plan_bytes_c),
    .awlen_c       (plan_len_c),
    .last_strb_c   (plan_strb_c),
    .line_end_c    (plan_end_c)
  );

  assign last_beat_c   = (beat_cnt_q == awlen_q);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(BEAT_SHIFT);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = (state_q == ST_W) && !i_fifo_empty;
  assign m_axi_wdata   = i_w_data;
  assign m_axi_wlast   = m_axi_wvalid && last_beat_c;
  assign m_axi_wstrb   = (last_beat_c && line_end_q) ? last_strb_q : '1;
  assign o_fifo_rd_en  = m_axi_wvalid && m_axi_wready;
  assign m_axi_bready  = (state_q == ST_B);
  assign o_busy        = busy_q;
  assign o_write_done  = done_q;
  assign o_write_error = err_q;

  // Transfer sequencing and address walk across bursts and lines.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    line_start_d = line_start_q;
    line_done_d  = line_done_q;
    line_cnt_d   = line_cnt_q;
    width_d      = width_q;
    height_d     = height_q;
    stride_d     = stride_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: if (i_start) begin
        err_d        = 1'b0;
        width_d      = i_img_width;
        height_d     = i_img_height;
        stride_d     = i_img_stride;
        addr_d       = i_dst_addr;
        line_start_d = i_dst_addr;
        line_done_d  = '0;
        line_cnt_d   = '0;
        state_d      = (i_img_width == '0 || i_img_height == '0) ? ST_DONE : ST_AW;
      end
      ST_AW: if (m_axi_awready) begin
        beat_cnt_d = '0;
        state_d    = ST_W;
      end
      ST_W: if (o_fifo_rd_en) begin
        beat_cnt_d = beat_cnt_q + 8'd1;
        if (last_beat_c) state_d = ST_B;
      end
      ST_B: if (m_axi_bvalid) begin
        if (m_axi_bresp != RESP_OKAY) err_d = 1'b1;
        if (line_end_q) begin
          line_start_d = line_start_q + AW'(stride_q);
          addr_d       = line_start_d;
          line_done_d  = '0;
          line_cnt_d   = line_cnt_q + 32'd1;
          state_d      = (line_cnt_d == height_q) ? ST_DONE : ST_AW;
        end else begin
          addr_d      = addr_q + AW'(burst_bytes_q);
          line_done_d = line_done_q + burst_bytes_q;
          state_d     = ST_AW;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture the burst plan on entry to AW and register the status outputs.
  always_comb begin
    awlen_d       = awlen_q;
    burst_bytes_d = burst_bytes_q;
    line_end_d    = line_end_q;
    last_strb_d   = last_strb_q;
    if (state_d == ST_AW) begin
      awlen_d       = plan_len_c;
      burst_bytes_d = plan_bytes_c;
      line_end_d    = plan_end_c;
      last_strb_d   = plan_strb_c;
    end
    awvalid_d = (state_d == ST_AW);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_q == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      line_start_q  <= '0;
      line_done_q   <= '0;
      line_cnt_q    <= '0;
      width_q       <= '0;
      height_q      <= '0;
      stride_q      <= '0;
      burst_bytes_q <= '0;
      awlen_q       <= '0;
      beat_cnt_q    <= '0;
      last_strb_q   <= '0;
      line_end_q    <= 1'b0;
      awvalid_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      line_start_q  <= line_start_d;
      line_done_q   <= line_done_d;
      line_cnt_q    <= line_cnt_d;
      width_q       <= width_d;
      height_q      <= height_d;
      stride_q      <= stride_d;
      burst_bytes_q <= burst_bytes_d;
      awlen_q       <= awlen_d;
      beat_cnt_q    <= beat_cnt_d;
      last_strb_q   <= last_strb_d;
      line_end_q    <= line_end_d;
      awvalid_q     <= awvalid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_2d_write_master_p.sv
// Bench for the 2D write master: AXI slave + FIFO model, expected bursts from a line/page walk.
module tb_axi_2d_write_master_p;
  import dma_axi_pkg::*;

  localparam int unsigned BB   = 4;
  localparam int unsigned MAXB = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_dst_addr, i_img_width, i_img_height, i_img_stride;
  logic        o_busy, o_write_done, o_write_error;
  logic        i_fifo_empty, o_fifo_rd_en;
  logic [31:0] i_w_data;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  int total = 0;
  int bad   = 0;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct packed { logic [3:0] strb; logic last; } w_exp_t;
  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];

  axi_2d_write_master_p #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_MAX_BURST_BEATS  (16)
  ) dut (
    .clk (clk), .reset_n (reset_n), .i_start (i_start),
    .i_dst_addr (i_dst_addr), .i_img_width (i_img_width),
    .i_img_height (i_img_height), .i_img_stride (i_img_stride),
    .o_busy (o_busy), .o_write_done (o_write_done), .o_write_error (o_write_error),
    .i_fifo_empty (i_fifo_empty), .o_fifo_rd_en (o_fifo_rd_en), .i_w_data (i_w_data),
    .m_axi_awaddr (m_axi_awaddr), .m_axi_awlen (m_axi_awlen), .m_axi_awsize (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst), .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
    .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wlast (m_axi_wlast),
    .m_axi_wvalid (m_axi_wvalid), .m_axi_wready (m_axi_wready),
    .m_axi_bresp (m_axi_bresp), .m_axi_bvalid (m_axi_bvalid), .m_axi_bready (m_axi_bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int unsigned k, input logic [31:0] seed);
    return (32'(k) * 32'h9E37_79B1) ^ seed;
  endfunction

  // Walk every line, cutting at max burst, line end and 4 KB pages.
  task automatic build_model(input logic [31:0] dst, w, h, stride);
    logic [31:0] ls, a, n, pg, off;
    int unsigned nb;
    w_exp_t      e;
    aw_q.delete();
    w_q.delete();
    for (int unsigned l = 0; l < h; l++) begin
      ls  = dst + 32'(l) * stride;
      off = 0;
      while (off < w) begin
        a  = ls + off;
        n  = MAXB * BB;
        if (w - off < n) n = w - off;
        pg = 32'd4096 - (a % 32'd4096);
        if (pg < n) n = pg;
        nb = (n + BB - 1) / BB;
        aw_q.push_back('{a, 8'(nb - 1)});
        for (int unsigned b = 0; b < nb; b++) begin
          e.strb = 4'hF;
          if (off + n == w && b == nb - 1 && (w % BB) != 0) e.strb = 4'((1 << (w % BB)) - 1);
          e.last = (b == nb - 1);
          w_q.push_back(e);
        end
        off += n;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_awvalid"}, m_axi_awvalid, 0);
    chk({tag, "_wvalid"},  m_axi_wvalid, 0);
    chk({tag, "_wlast"},   m_axi_wlast, 0);
    chk({tag, "_bready"},  m_axi_bready, 0);
    chk({tag, "_busy"},    o_busy, 0);
    chk({tag, "_done"},    o_write_done, 0);
    chk({tag, "_error"},   o_write_error, 0);
    chk({tag, "_rd_en"},   o_fifo_rd_en, 0);
  endtask

  task automatic run_xfer(input logic [31:0] dst, w, h, stride, input int err_burst,
                          input int stall_beat, input int rst_beat, input bit jitter,
                          input string name);
    int          it, b_idx, data_idx, stall_left, last_b_it, done_it, nbursts, nbeats;
    bit          b_pend, bv, exp_err, aw_next_chk, aw_next_exp, done_seen, do_rst;
    logic [31:0] seed;
    aw_exp_t     ea;
    w_exp_t      ew;
    build_model(dst, w, h, stride);
    nbursts = aw_q.size();
    nbeats  = w_q.size();
    exp_err = (err_burst >= 0) && (err_burst < nbursts);
    seed = $urandom;
    b_idx = 0; data_idx = 0; stall_left = 0; last_b_it = 0; done_it = 0;
    b_pend = 0; bv = 0; aw_next_chk = 0; aw_next_exp = 0; done_seen = 0; do_rst = 0;
    for (it = 0; it < 4000 && !done_seen && !do_rst; it++) begin
      @(negedge clk);
      i_start = (it == 0) || (it == 3);
      if (it == 0) begin
        i_dst_addr = dst; i_img_width = w; i_img_height = h; i_img_stride = stride;
      end else begin
        i_dst_addr = $urandom; i_img_width = $urandom; i_img_height = $urandom; i_img_stride = $urandom;
      end
      m_axi_awready = jitter ? 1'($urandom % 2) : 1'b1;
      m_axi_wready  = jitter ? ($urandom % 4 != 0) : 1'b1;
      if (stall_left > 0) begin
        i_fifo_empty = 1'b1;
        m_axi_wready = 1'b1;
      end else begin
        i_fifo_empty = jitter ? ($urandom % 5 == 0) : 1'b0;
      end
      i_w_data = i_fifo_empty ? $urandom : word_of(data_idx, seed);
      if (b_pend && !bv && (!jitter || $urandom % 2 == 0)) bv = 1'b1;
      m_axi_bvalid = bv;
      m_axi_bresp  = (b_idx == err_burst) ? RESP_SLVERR : RESP_OKAY;
      #1;
      if (it == 1) begin
        chk({name, "_busy_after_start"}, o_busy, 1);
        chk({name, "_error_cleared"}, o_write_error, 0);
        chk({name, "_awvalid_after_start"}, m_axi_awvalid, nbursts != 0);
      end
      if (aw_next_chk) begin
        chk({name, "_awvalid_after_b"}, m_axi_awvalid, aw_next_exp);
        aw_next_chk = 0;
      end
      chk({name, "_rd_en"}, o_fifo_rd_en, m_axi_wvalid && m_axi_wready);
      if (i_fifo_empty) chk({name, "_wvalid_when_empty"}, m_axi_wvalid, 0);
      if (stall_left > 0) stall_left--;
      if (m_axi_awvalid) begin
        if (aw_q.size() == 0) chk({name, "_spurious_aw"}, m_axi_awvalid, 0);
        else if (m_axi_awready) begin
          ea = aw_q.pop_front();
          chk({name, "_awaddr"}, m_axi_awaddr, ea.addr);
          chk({name, "_awlen"}, m_axi_awlen, ea.len);
          chk({name, "_awsize"}, m_axi_awsize, 3'd2);
          chk({name, "_awburst"}, m_axi_awburst, BURST_INCR);
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_q.size() == 0) chk({name, "_extra_beat"}, m_axi_wvalid, 0);
        else begin
          ew = w_q.pop_front();
          chk({name, "_wdata"}, m_axi_wdata, word_of(data_idx, seed));
          chk({name, "_wstrb"}, m_axi_wstrb, ew.strb);
          chk({name, "_wlast"}, m_axi_wlast, ew.last);
          data_idx++;
          if (ew.last) b_pend = 1'b1;
          if (data_idx == stall_beat) stall_left = 5;
          if (rst_beat >= 0 && data_idx == rst_beat) do_rst = 1'b1;
        end
      end
      if (bv && m_axi_bready) begin
        bv = 1'b0; b_pend = 1'b0; b_idx++;
        last_b_it = it;
        aw_next_chk = 1'b1;
        aw_next_exp = (b_idx < nbursts);
      end
      if (o_write_done) begin
        done_seen = 1'b1;
        done_it = it;
      end
    end
    i_start = 1'b0;
    m_axi_bvalid = 1'b0;
    if (do_rst) begin
      @(negedge clk);
      reset_n = 1'b0;
      i_fifo_empty = 1'b0;
      @(negedge clk);
      #1;
      check_all_zero({name, "_midreset"});
      reset_n = 1'b1;
      @(negedge clk);
      return;
    end
    chk({name, "_done_seen"}, done_seen, 1);
    if (done_seen) begin
      chk({name, "_done_timing"}, done_it, (nbursts == 0) ? 2 : last_b_it + 2);
      chk({name, "_busy_at_done"}, o_busy, 0);
      chk({name, "_error_at_done"}, o_write_error, exp_err);
      chk({name, "_aw_left"}, aw_q.size(), 0);
      chk({name, "_beats_left"}, w_q.size(), 0);
      chk({name, "_pops"}, data_idx, nbeats);
      @(negedge clk);
      #1;
      chk({name, "_done_one_cycle"}, o_write_done, 0);
    end else begin
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rw;
    reset_n = 1'b0; i_start = 1'b0;
    i_dst_addr = '0; i_img_width = '0; i_img_height = '0; i_img_stride = '0;
    i_fifo_empty = 1'b1; i_w_data = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = RESP_OKAY;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_xfer(32'h1000, 64, 2, 256, -1, -1, -1, 1'b0, "two_lines");
    run_xfer(32'h0FF0, 48, 1, 64,  -1, -1, -1, 1'b0, "page_split");
    run_xfer(32'h2000, 10, 1, 16,  -1, -1, -1, 1'b0, "partial_strb");
    run_xfer(32'h3000, 0,  5, 64,  -1, -1, -1, 1'b0, "zero_width");
    run_xfer(32'h3000, 8,  0, 64,  -1, -1, -1, 1'b0, "zero_height");
    run_xfer(32'h4000, 64, 3, 64,   1, -1, -1, 1'b0, "slverr");
    run_xfer(32'h4800, 20, 1, 32,  -1, -1, -1, 1'b0, "error_cleared");
    run_xfer(32'h5000, 64, 2, 128, -1,  5, -1, 1'b0, "fifo_stall");
    run_xfer(32'h6000, 64, 1, 64,   0, -1,  3, 1'b0, "reset_mid_w");
    run_xfer(32'h0FE0, 70, 3, 4092, -1, -1, -1, 1'b1, "page_jitter");

    for (int r = 0; r < 8; r++) begin
      rw = 32'($urandom_range(1, 300));
      run_xfer($urandom & 32'h0000_FFFC, rw, 32'($urandom_range(1, 3)),
               ((rw + 3) & ~32'd3) + 32'(4 * $urandom_range(0, 8)),
               int'($urandom_range(0, 3)) - 1, -1, -1, 1'b1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
